// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: issues IMemory reads, tracks the one in-flight word and queues {pc, instr} for decode.
// Credit rule: a read is only issued when the FIFO is sure to have room for the returning word.
module instr_fetch_unit #(
    parameter int          ADDR_W   = 10,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_instr
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [63:0]   fifo_mem [DEPTH];
    logic          pop;
    logic          issue;

    always_comb begin
        out_valid = (count != '0) & ~rst;
        pop       = out_valid & out_ready;
        issue     = fetch_en & ~redirect_valid & ~rst &
                    (({1'b0, count} + (CW+1)'(inflight)) < ((CW+1)'(DEPTH) + (CW+1)'(pop)));
        imem_en   = issue;
        imem_addr = fetch_pc[ADDR_W+1:2];
        out_pc    = fifo_mem[rd_ptr][63:32];
        out_instr = fifo_mem[rd_ptr][31:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 32'd4;
            end
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & ~32'h3;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                // a word is captured the cycle after its read, even if fetching has since paused
                if (inflight) begin
                    fifo_mem[wr_ptr] <= {inflight_pc, imem_rdata};
                    wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                end
                if (pop)
                    rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
                count <= count + CW'(inflight) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed phases then random traffic; every issued fetch is queued as an expected
// decode entry and a negedge monitor checks issue, address, out_valid timing and popped {pc, instr}.
module tb_instr_fetch_unit;
    localparam int          ADDR_W   = 10;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fetch_en = 1'b0;
    logic              redirect_valid = 1'b0;
    logic [31:0]       redirect_pc = '0;
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_pc;
    logic [31:0]       out_instr;

    typedef struct {
        logic [31:0] pc;
        int          t;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem [2**ADDR_W];
    logic [31:0] iss_pc = RESET_PC;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    instr_fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (imem_en) imem_rdata <= mem[imem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference: an issued word becomes visible two cycles later and leaves in issue order;
    // outstanding words (issued, not yet popped) never exceed DEPTH.
    always @(negedge clk) begin
        logic exp_v, exp_pop, exp_iss;
        logic [31:0] pc;
        exp_v = !rst && exp_q.size() > 0 && exp_q[0].t + 2 <= cyc;
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
        exp_pop = exp_v && out_ready;
        if (exp_pop) begin
            pc = exp_q[0].pc;
            if (out_valid) begin
                chk("out_pc", out_pc, pc);
                chk("out_instr", out_instr, mem[pc[ADDR_W+1:2]]);
            end
            void'(exp_q.pop_front());
        end
        exp_iss = fetch_en && !redirect_valid && !rst && (exp_q.size() < DEPTH);
        chk("imem_en", {31'b0, imem_en}, {31'b0, exp_iss});
        if (exp_iss) begin
            if (imem_en) chk("imem_addr", {{(32-ADDR_W){1'b0}}, imem_addr}, {{(32-ADDR_W){1'b0}}, iss_pc[ADDR_W+1:2]});
            exp_q.push_back('{pc: iss_pc, t: cyc});
            iss_pc = iss_pc + 32'd4;
        end
        if (rst) begin
            exp_q.delete();
            iss_pc = RESET_PC;
        end else if (redirect_valid) begin
            exp_q.delete();
            iss_pc = {redirect_pc[31:2], 2'b00};
        end
        cyc++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc = target;
        step(1);
        redirect_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) mem[i] = $urandom;
        // boot: cycle 0 is the first cycle with rst low
        @(posedge clk);
        @(posedge clk);
        #1;
        cyc = 0;
        rst = 1'b0;
        fetch_en = 1'b1;
        out_ready = 1'b1;
        step(20);
        // backpressure
        out_ready = 1'b0;
        step(6);
        out_ready = 1'b1;
        step(10);
        // redirect while full with a read in flight
        out_ready = 1'b0;
        step(4);
        redirect(32'h100);
        out_ready = 1'b1;
        step(10);
        // misaligned target
        redirect(32'h103);
        step(8);
        // address wrap
        redirect(32'hFF8);
        step(10);
        // reset mid-stream with FIFO non-empty
        out_ready = 1'b0;
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        out_ready = 1'b1;
        step(10);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            fetch_en = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 99) < 4);
            redirect_pc = (($urandom_range(0, 3) == 0) ? 32'h0000_0FF0 : 32'h0) + $urandom_range(0, 4095);
            rst = ($urandom_range(0, 199) == 0);
            step(1);
        end
        // drain
        rst = 1'b0;
        redirect_valid = 1'b0;
        fetch_en = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) step(1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries still expected, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
